voice_allocator: RTL and testbench
==================================

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter STEP_CYCLES, default 2500000, attack step period in clk cycles (minimum 1).
REQ-002 Parameter REL_STEP_CYCLES, default 10000000, release step period in clk cycles (minimum 1).
REQ-003 clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 ev_valid  input  1  key event present.
REQ-006 ev_ready  output  1  block can accept an event this cycle.
REQ-007 ev_note  input  8  note code of the event (0 is reserved and never sent).
REQ-008 ev_press  input  1  1 = key press, 0 = key release.
REQ-009 note1, note2, note3  output  8 each  note code of voices 0..2; 0 when voice idle.
REQ-010 shift1, shift2, shift3  output  4 each  attenuation shift of voices 0..2, range 0..8.
REQ-011 active  output  3  bit v = 1 when voice v is not IDLE.

Function
REQ-012 An event SHALL be accepted on a cycle with ev_valid and ev_ready both high; ev_ready SHALL drop for exactly the one cycle following each accept, and is otherwise high.
REQ-013 Per-voice state machine SHALL have states IDLE, ATTACK, SUSTAIN, RELEASE.
REQ-014 Press of note N SHALL select a voice by priority: a non-IDLE voice already holding N (retrigger); else the lowest-index IDLE voice; else the lowest-index RELEASE voice; else the voice with the highest age rank.
REQ-015 The selected voice SHALL, on the cycle after accept, hold note N, state ATTACK, shift 8, step counter 0, age rank 0.
REQ-016 On allocation, every other non-IDLE voice whose rank was lower than the selected voice's previous rank SHALL increment its rank; ranks saturate at 2.
REQ-017 Release of note N SHALL move every voice holding N in ATTACK or SUSTAIN to RELEASE with shift unchanged and step counter cleared; a release matching no such voice SHALL be ignored with no state change.
REQ-018 In ATTACK, shift SHALL decrement by 1 every STEP_CYCLES cycles; when it reaches 0 the voice SHALL enter SUSTAIN on the same cycle.
REQ-019 In SUSTAIN, shift SHALL remain 0 indefinitely until released or stolen.
REQ-020 In RELEASE, shift SHALL increment by 1 every REL_STEP_CYCLES cycles; when it reaches 8 the voice SHALL enter IDLE on the same cycle and its note output SHALL read 0 from the next cycle.
REQ-021 An accepted event targeting a voice SHALL override that voice's step-counter update in the same cycle.
REQ-022 Step counters SHALL be wide enough for the parameter value and SHALL wrap to 0 on each step.
REQ-023 All outputs SHALL be registered; latency from accept to updated noteX/shiftX/active SHALL be 1 cycle.

Reset
REQ-024 While rst_n is low at posedge clk: all voices IDLE, noteX = 0, shiftX = 8, active = 0, ranks 0, step counters 0, ev_ready = 0.
REQ-025 ev_ready SHALL be 1 on the first cycle after rst_n returns high; reset mid-envelope SHALL discard all voice state with no residual output.

Structure
REQ-026 Shared package piano_pkg SHALL hold env_state_t (IDLE, ATTACK, SUSTAIN, RELEASE), NUM_VOICES = 3 and MAX_SHIFT = 8.
REQ-027 One sub-module voice_env SHALL implement a single voice's state machine, step counter and shift; voice_allocator instantiates three and contains the match/priority/rank logic.

Verification (STEP_CYCLES = 4, REL_STEP_CYCLES = 8)
REQ-028 Press 0x3C -> next cycle note1 = 0x3C, shift1 = 8, active = 001; shift1 reaches 0 and SUSTAIN 32 cycles later.
REQ-029 Press 0x3C, 0x40, 0x43, then 0x48 -> 0x48 steals voice 0 (oldest), note1 = 0x48, shift1 = 8, notes 2/3 unchanged.
REQ-030 In SUSTAIN, release 0x3C -> shift1 increments every 8 cycles, reaches 8 after 64 cycles, then note1 = 0 and active bit 0 clears.
REQ-031 Re-press 0x3C while voice 0 is in RELEASE at shift 5 -> same voice retriggered: shift1 = 8, ATTACK, no other voice touched.
REQ-032 Release 0x50 with no voice holding it -> all outputs unchanged; ev_ready low for exactly one cycle after accept.
REQ-033 Assert rst_n low during ATTACK on all voices -> next cycle all notes 0, shifts 8, active 000, ev_ready 0.

Source files
------------

// File: rtl/piano_pkg.sv
// rtl/piano_pkg.sv - shared envelope types and voice constants
package piano_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } env_state_t;

  localparam int NUM_VOICES = 3;
  localparam int MAX_SHIFT  = 8;
  localparam logic [3:0] SHIFT_MAX = 4'(MAX_SHIFT);

endpackage

// File: rtl/voice_env.sv
// rtl/voice_env.sv - one voice: envelope state, step counter and attenuation shift
module voice_env
  import piano_pkg::*;
#(
  parameter int STEP_CYCLES     = 2500000,
  parameter int REL_STEP_CYCLES = 10000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       release_hit,
  input  logic [7:0] start_note,
  output env_state_t state,
  output logic [7:0] note,
  output logic [3:0] shift,
  output logic       active
);

  localparam int CMAX = (STEP_CYCLES > REL_STEP_CYCLES) ? STEP_CYCLES : REL_STEP_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] ATK_LAST = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] REL_LAST = CW'(REL_STEP_CYCLES - 1);

  env_state_t    state_q, state_d;
  logic [7:0]    note_q, note_d;
  logic [3:0]    shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          active_q, active_d;

  always_comb begin
    state_d = state_q;
    note_d  = note_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    case (state_q)
      ATTACK: begin
        if (cnt_q == ATK_LAST) begin
          cnt_d   = '0;
          shift_d = shift_q - 4'd1;
          if (shift_q == 4'd1) state_d = SUSTAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        if (cnt_q == REL_LAST) begin
          cnt_d = '0;
          // A voice released straight from shift 8 still waits one step before idling
          if (shift_q >= SHIFT_MAX - 4'd1) begin
            shift_d = SHIFT_MAX;
            state_d = IDLE;
            note_d  = 8'd0;
          end else begin
            shift_d = shift_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: cnt_d = '0;
    endcase

    if (start) begin
      state_d = ATTACK;
      note_d  = start_note;
      shift_d = SHIFT_MAX;
      cnt_d   = '0;
    end else if (release_hit && (state_q == ATTACK || state_q == SUSTAIN)) begin
      state_d = RELEASE;
      shift_d = shift_q;
      cnt_d   = '0;
    end
    active_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      note_q   <= 8'd0;
      shift_q  <= SHIFT_MAX;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      note_q   <= note_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign state  = state_q;
  assign note   = note_q;
  assign shift  = shift_q;
  assign active = active_q;

endmodule

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - three-voice key allocator with retrigger, steal and age ranking
module voice_allocator
  import piano_pkg::*;
#(
  parameter int STEP_CYCLES     = 2500000,
  parameter int REL_STEP_CYCLES = 10000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ev_valid,
  output logic       ev_ready,
  input  logic [7:0] ev_note,
  input  logic       ev_press,
  output logic [7:0] note1,
  output logic [7:0] note2,
  output logic [7:0] note3,
  output logic [3:0] shift1,
  output logic [3:0] shift2,
  output logic [3:0] shift3,
  output logic [2:0] active
);

  env_state_t            st [NUM_VOICES];
  logic [7:0]            nt [NUM_VOICES];
  logic [3:0]            sh [NUM_VOICES];
  logic [NUM_VOICES-1:0] act, start, rel_hit;
  logic [1:0]            rank_q [NUM_VOICES];
  logic [1:0]            rank_d [NUM_VOICES];
  logic                  ev_ready_q, ev_ready_d;
  logic                  accept, found;
  logic [1:0]            sel;
  logic [2:0]            prev_rank;

  assign accept = ev_valid && ev_ready_q;

  always_comb begin
    found = 1'b0;
    sel   = 2'd0;
    for (int v = 0; v < NUM_VOICES; v++)
      if (!found && st[v] != IDLE && nt[v] == ev_note) begin found = 1'b1; sel = 2'(v); end
    for (int v = 0; v < NUM_VOICES; v++)
      if (!found && st[v] == IDLE) begin found = 1'b1; sel = 2'(v); end
    for (int v = 0; v < NUM_VOICES; v++)
      if (!found && st[v] == RELEASE) begin found = 1'b1; sel = 2'(v); end
    if (!found)
      for (int v = 1; v < NUM_VOICES; v++)
        if (rank_q[v] > rank_q[sel]) sel = 2'(v);
  end

  // An idle voice being claimed counts as older than everything, so all live voices age
  always_comb begin
    ev_ready_d = !accept;
    prev_rank  = (st[sel] == IDLE) ? 3'd4 : {1'b0, rank_q[sel]};
    start      = '0;
    rel_hit    = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      rank_d[v]  = rank_q[v];
      start[v]   = accept && ev_press && (sel == 2'(v));
      rel_hit[v] = accept && !ev_press && st[v] != IDLE && nt[v] == ev_note;
      if (accept && ev_press) begin
        if (sel == 2'(v))
          rank_d[v] = 2'd0;
        else if (st[v] != IDLE && {1'b0, rank_q[v]} < prev_rank && rank_q[v] != 2'd2)
          rank_d[v] = rank_q[v] + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ev_ready_q <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) rank_q[v] <= 2'd0;
    end else begin
      ev_ready_q <= ev_ready_d;
      for (int v = 0; v < NUM_VOICES; v++) rank_q[v] <= rank_d[v];
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
    voice_env #(
      .STEP_CYCLES    (STEP_CYCLES),
      .REL_STEP_CYCLES(REL_STEP_CYCLES)
    ) u_env (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start[g]),
      .release_hit(rel_hit[g]),
      .start_note (ev_note),
      .state      (st[g]),
      .note       (nt[g]),
      .shift      (sh[g]),
      .active     (act[g])
    );
  end

  assign ev_ready = ev_ready_q;
  assign note1    = nt[0];
  assign note2    = nt[1];
  assign note3    = nt[2];
  assign shift1   = sh[0];
  assign shift2   = sh[1];
  assign shift3   = sh[2];
  assign active   = act;

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - scoreboard bench for voice_allocator against a reference model
module tb_voice_allocator;

  localparam int STEP = 4;
  localparam int REL  = 8;
  localparam int S_IDLE = 0, S_ATK = 1, S_SUS = 2, S_REL = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ev_valid = 1'b0;
  logic       ev_press = 1'b0;
  logic [7:0] ev_note = 8'd0;
  logic       ev_ready;
  logic [7:0] note1, note2, note3;
  logic [3:0] shift1, shift2, shift3;
  logic [2:0] active;

  voice_allocator #(.STEP_CYCLES(STEP), .REL_STEP_CYCLES(REL)) dut (
    .clk(clk), .rst_n(rst_n), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_note(ev_note), .ev_press(ev_press),
    .note1(note1), .note2(note2), .note3(note3),
    .shift1(shift1), .shift2(shift2), .shift3(shift3), .active(active)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] n1, n2, n3;
    logic [3:0] s1, s2, s3;
    logic [2:0] act;
    logic       rdy;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  int m_st[3], m_note[3], m_shift[3], m_cnt[3], m_rank[3];
  int o_st[3], o_note[3], o_shift[3], o_rank[3];
  bit m_rdy = 1'b0;
  bit acc;
  int sel, prev;
  exp_t e_m;

  // Reference model: one evaluation per clock, expected outputs queued for the monitor
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      for (int v = 0; v < 3; v++) begin
        m_st[v] = S_IDLE; m_note[v] = 0; m_shift[v] = 8; m_cnt[v] = 0; m_rank[v] = 0;
      end
      m_rdy = 1'b0;
    end else begin
      acc = ev_valid && m_rdy;
      o_st = m_st; o_note = m_note; o_shift = m_shift; o_rank = m_rank;
      for (int v = 0; v < 3; v++) begin
        if (m_st[v] == S_ATK) begin
          if (m_cnt[v] == STEP - 1) begin
            m_cnt[v] = 0;
            m_shift[v] = m_shift[v] - 1;
            if (m_shift[v] == 0) m_st[v] = S_SUS;
          end else m_cnt[v]++;
        end else if (m_st[v] == S_REL) begin
          if (m_cnt[v] == REL - 1) begin
            m_cnt[v] = 0;
            m_shift[v] = (m_shift[v] + 1 > 8) ? 8 : m_shift[v] + 1;
            if (m_shift[v] == 8) begin m_st[v] = S_IDLE; m_note[v] = 0; end
          end else m_cnt[v]++;
        end
      end
      if (acc && ev_press) begin
        sel = -1;
        for (int v = 0; v < 3; v++) if (sel < 0 && o_st[v] != S_IDLE && o_note[v] == int'(ev_note)) sel = v;
        for (int v = 0; v < 3; v++) if (sel < 0 && o_st[v] == S_IDLE) sel = v;
        for (int v = 0; v < 3; v++) if (sel < 0 && o_st[v] == S_REL) sel = v;
        if (sel < 0) begin
          sel = 0;
          for (int v = 1; v < 3; v++) if (o_rank[v] > o_rank[sel]) sel = v;
        end
        prev = (o_st[sel] == S_IDLE) ? 99 : o_rank[sel];
        for (int v = 0; v < 3; v++)
          if (v != sel && o_st[v] != S_IDLE && o_rank[v] < prev)
            m_rank[v] = (o_rank[v] + 1 > 2) ? 2 : o_rank[v] + 1;
        m_rank[sel] = 0; m_st[sel] = S_ATK; m_note[sel] = int'(ev_note);
        m_shift[sel] = 8; m_cnt[sel] = 0;
      end else if (acc) begin
        for (int v = 0; v < 3; v++)
          if ((o_st[v] == S_ATK || o_st[v] == S_SUS) && o_note[v] == int'(ev_note)) begin
            m_st[v] = S_REL; m_cnt[v] = 0; m_shift[v] = o_shift[v];
          end
      end
      m_rdy = !acc;
    end
    e_m.n1 = 8'(m_note[0]); e_m.n2 = 8'(m_note[1]); e_m.n3 = 8'(m_note[2]);
    e_m.s1 = 4'(m_shift[0]); e_m.s2 = 4'(m_shift[1]); e_m.s3 = 4'(m_shift[2]);
    e_m.act = {m_st[2] != S_IDLE, m_st[1] != S_IDLE, m_st[0] != S_IDLE};
    e_m.rdy = m_rdy;
    expq.push_back(e_m);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, got, exp);
    end
  endtask

  exp_t e_c;
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      e_c = expq.pop_front();
      chk("note1", 32'(note1), 32'(e_c.n1));
      chk("note2", 32'(note2), 32'(e_c.n2));
      chk("note3", 32'(note3), 32'(e_c.n3));
      chk("shift1", 32'(shift1), 32'(e_c.s1));
      chk("shift2", 32'(shift2), 32'(e_c.s2));
      chk("shift3", 32'(shift3), 32'(e_c.s3));
      chk("active", 32'(active), 32'(e_c.act));
      chk("ev_ready", 32'(ev_ready), 32'(e_c.rdy));
    end
  end

  task automatic send(input logic [7:0] n, input logic p);
    int k = 0;
    while (ev_ready !== 1'b1 && k < 10) begin @(negedge clk); k++; end
    ev_valid = 1'b1; ev_note = n; ev_press = p;
    @(negedge clk);
    ev_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] notes [5] = '{8'h3C, 8'h40, 8'h43, 8'h48, 8'h50};

  initial begin
    idle(3);
    rst_n = 1'b1;
    idle(2);
    send(8'h3C, 1'b1); idle(40);
    send(8'h3C, 1'b0); idle(70);
    send(8'h3C, 1'b1); send(8'h40, 1'b1); send(8'h43, 1'b1); send(8'h48, 1'b1);
    idle(5);
    send(8'h50, 1'b0); idle(3);
    send(8'h48, 1'b0); idle(44);
    send(8'h48, 1'b1); idle(4);
    ev_valid = 1'b1; ev_note = 8'h40; ev_press = 1'b0; idle(4); ev_valid = 1'b0;
    send(8'h3C, 1'b1); send(8'h40, 1'b1); idle(6);
    rst_n = 1'b0; idle(2); rst_n = 1'b1; idle(3);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      ev_valid = (i < 1500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      ev_note  = notes[$urandom_range(0, 4)];
      ev_press = ($urandom_range(0, 9) < 6);
      rst_n    = ($urandom_range(0, 999) != 0);
    end
    ev_valid = 1'b0; rst_n = 1'b1;
    idle(3);
    chk("queue_drained", 32'(expq.size() <= 1), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
